// File: rtl/spi_slave_tx_sched_if.sv
// Scheduler-facing bundle: TX FIFO pop port, shifter control and transfer status.
// master drives requests and shifter feedback; slave is the scheduler.
interface spi_slave_tx_sched_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  start_i;
   logic                  quad_i;
   logic [7:0]            dummy_i;
   logic [15:0]           words_i;
   logic [DATA_WIDTH-1:0] fifo_data_i;
   logic                  fifo_valid_i;
   logic                  fifo_ready_o;
   logic [DATA_WIDTH-1:0] tx_data_o;
   logic                  tx_data_valid_o;
   logic [7:0]            tx_counter_o;
   logic                  tx_counter_upd_o;
   logic                  tx_en_quad_o;
   logic [1:0]            tx_pad_mode_o;
   logic                  tx_done_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  underrun_o;
   logic [15:0]           words_sent_o;

   modport master (
      output start_i, quad_i, dummy_i, words_i,
      output fifo_data_i, fifo_valid_i, tx_done_i,
      input  fifo_ready_o, tx_data_o, tx_data_valid_o,
      input  tx_counter_o, tx_counter_upd_o,
      input  tx_en_quad_o, tx_pad_mode_o,
      input  busy_o, done_o, underrun_o, words_sent_o
   );

   modport slave (
      input  start_i, quad_i, dummy_i, words_i,
      input  fifo_data_i, fifo_valid_i, tx_done_i,
      output fifo_ready_o, tx_data_o, tx_data_valid_o,
      output tx_counter_o, tx_counter_upd_o,
      output tx_en_quad_o, tx_pad_mode_o,
      output busy_o, done_o, underrun_o, words_sent_o
   );
endinterface

// File: rtl/spi_slave_tx_sched.sv
// SPI slave TX sequencer: dummy turnaround, FIFO pop and shifter (re)load per word.
// Runs entirely on sclk; cs high is the asynchronous reset / abort.
module spi_slave_tx_sched #(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD = 32'hDEAD_BEEF
) (
   input logic                 sclk,
   input logic                 cs,
   spi_slave_tx_sched_if.slave bus
);
   localparam logic [7:0] TGT_STD  = 8'(DATA_WIDTH - 1);
   localparam logic [7:0] TGT_QUAD = 8'(DATA_WIDTH / 4 - 1);

   localparam logic [1:0] PAD_STD_TX  = 2'b00;
   localparam logic [1:0] PAD_STD_RX  = 2'b01;
   localparam logic [1:0] PAD_QUAD_TX = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      DUMMY,
      LOAD,
      SHIFT,
      FIN
   } state_t;

   state_t                state;
   logic                  quad_q;
   logic [7:0]            dummy_cnt;
   logic [15:0]           words_q;
   logic [15:0]           words_sent_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [1:0]            pad_q;
   logic                  en_quad_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  underrun_q;

   logic                  more;
   logic                  issue;
   logic [7:0]            tgt;
   logic [DATA_WIDTH-1:0] word;

   // A zero word budget means the transfer only ends on cs.
   assign more = (words_q == 16'd0) || (words_sent_q != words_q);
   assign tgt  = quad_q ? TGT_QUAD : TGT_STD;
   assign word = bus.fifo_valid_i ? bus.fifo_data_i : FILL_WORD;

   always_comb begin
      issue = 1'b0;
      unique case (state)
         LOAD:    issue = 1'b1;
         SHIFT:   issue = bus.tx_done_i && more;
         default: issue = 1'b0;
      endcase
   end

   assign bus.fifo_ready_o     = issue && bus.fifo_valid_i;
   assign bus.tx_data_valid_o  = issue;
   assign bus.tx_counter_upd_o = issue;
   assign bus.tx_counter_o     = issue ? tgt : 8'd0;
   assign bus.tx_data_o        = issue ? word : data_q;
   assign bus.tx_en_quad_o     = en_quad_q;
   assign bus.tx_pad_mode_o    = pad_q;
   assign bus.busy_o           = busy_q;
   assign bus.done_o           = done_q;
   assign bus.underrun_o       = underrun_q;
   assign bus.words_sent_o     = words_sent_q;

   always_ff @(posedge sclk or posedge cs) begin
      if (cs) begin
         state        <= IDLE;
         quad_q       <= 1'b0;
         dummy_cnt    <= 8'd0;
         words_q      <= 16'd0;
         words_sent_q <= 16'd0;
         data_q       <= '0;
         pad_q        <= PAD_STD_RX;
         en_quad_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (issue) begin
            data_q       <= word;
            words_sent_q <= words_sent_q + 16'd1;
            if (!bus.fifo_valid_i) begin
               underrun_q <= 1'b1;
            end
         end
         unique case (state)
            IDLE: begin
               if (bus.start_i) begin
                  quad_q       <= bus.quad_i;
                  words_q      <= bus.words_i;
                  words_sent_q <= 16'd0;
                  underrun_q   <= 1'b0;
                  busy_q       <= 1'b1;
                  if (bus.dummy_i != 8'd0) begin
                     dummy_cnt <= bus.dummy_i - 8'd1;
                     pad_q     <= PAD_STD_RX;
                     state     <= DUMMY;
                  end else begin
                     pad_q     <= bus.quad_i ? PAD_QUAD_TX : PAD_STD_TX;
                     en_quad_q <= bus.quad_i;
                     state     <= LOAD;
                  end
               end
            end
            DUMMY: begin
               if (dummy_cnt == 8'd0) begin
                  pad_q     <= quad_q ? PAD_QUAD_TX : PAD_STD_TX;
                  en_quad_q <= quad_q;
                  state     <= LOAD;
               end else begin
                  dummy_cnt <= dummy_cnt - 8'd1;
               end
            end
            LOAD: begin
               state <= SHIFT;
            end
            SHIFT: begin
               if (bus.tx_done_i && !more) begin
                  done_q    <= 1'b1;
                  pad_q     <= PAD_STD_RX;
                  en_quad_q <= 1'b0;
                  state     <= FIN;
               end
            end
            FIN: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave_tx_sched.sv
// Scoreboard bench for spi_slave_tx_sched with a FIFO model and a fixed-length shifter model.
module tb_spi_slave_tx_sched;
   logic sclk = 1'b0;
   logic cs   = 1'b1;

   spi_slave_tx_sched_if #(.DATA_WIDTH(32)) bus ();

   spi_slave_tx_sched #(
      .DATA_WIDTH(32),
      .FILL_WORD (32'hDEAD_BEEF)
   ) dut (
      .sclk(sclk),
      .cs  (cs),
      .bus (bus)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic [31:0] data;
      logic        pop;
      logic [7:0]  tgt;
      logic [1:0]  pad;
      logic        quad;
   } iss_t;

   typedef struct {
      logic [15:0] ws;
      logic        urun;
   } dn_t;

   iss_t        exp_q[$];
   dn_t         dn_q[$];
   logic [31:0] fifo_q[$];
   int          issue_cyc[$];
   int          done_cyc[$];

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int n_issue  = 0;
   int n_done   = 0;
   int n_pop    = 0;
   int n_txdone = 0;
   int rem      = 0;
   int shift_len = 3;
   int p0;
   int b;
   int k;

   logic        force_done = 1'b0;
   logic        ld_neg     = 1'b0;
   logic        pop_pend   = 1'b0;
   logic [31:0] last_data  = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic exp_issue(input logic [31:0] d, input logic p, input logic q);
      iss_t e;
      e.data = d;
      e.pop  = p;
      e.quad = q;
      e.tgt  = q ? 8'd7 : 8'd31;
      e.pad  = q ? 2'b10 : 2'b00;
      exp_q.push_back(e);
   endtask

   task automatic exp_done(input logic [15:0] ws, input logic u);
      dn_t d;
      d.ws   = ws;
      d.urun = u;
      dn_q.push_back(d);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_fifo_ready"}, 32'(bus.fifo_ready_o), 32'd0);
      chk({nm, "_tx_data"}, bus.tx_data_o, 32'd0);
      chk({nm, "_tx_valid"}, 32'(bus.tx_data_valid_o), 32'd0);
      chk({nm, "_tx_counter"}, 32'(bus.tx_counter_o), 32'd0);
      chk({nm, "_counter_upd"}, 32'(bus.tx_counter_upd_o), 32'd0);
      chk({nm, "_en_quad"}, 32'(bus.tx_en_quad_o), 32'd0);
      chk({nm, "_pad"}, 32'(bus.tx_pad_mode_o), 32'd1);
      chk({nm, "_busy"}, 32'(bus.busy_o), 32'd0);
      chk({nm, "_done"}, 32'(bus.done_o), 32'd0);
      chk({nm, "_underrun"}, 32'(bus.underrun_o), 32'd0);
      chk({nm, "_words_sent"}, 32'(bus.words_sent_o), 32'd0);
   endtask

   task automatic start_xfer(input logic q, input logic [7:0] d, input logic [15:0] w);
      @(posedge sclk);
      #1;
      bus.start_i = 1'b1;
      bus.quad_i  = q;
      bus.dummy_i = d;
      bus.words_i = w;
      @(posedge sclk);
      #1;
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(input int lim, input string nm);
      int base;
      int n;
      base = n_done;
      n = 0;
      while (n_done == base && n < lim) begin
         @(posedge sclk);
         n++;
      end
      chk(nm, 32'(n_done != base), 32'd1);
   endtask

   // FIFO and shifter models: update just after each rising edge.
   always @(posedge sclk) begin
      cyc++;
      #1;
      if (pop_pend && fifo_q.size() != 0) begin
         fifo_q.delete(0);
         n_pop++;
      end
      bus.fifo_valid_i = (fifo_q.size() != 0);
      bus.fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
      if (cs) rem = 0;
      else if (ld_neg) rem = shift_len;
      else if (rem != 0) rem--;
      bus.tx_done_i = (rem == 1) || force_done;
      if (bus.tx_done_i) n_txdone++;
   end

   // Monitor: samples mid-cycle and checks against the scoreboard queues.
   always @(negedge sclk or posedge cs) begin
      iss_t e;
      dn_t  d;
      if (cs) begin
         ld_neg    = 1'b0;
         pop_pend  = 1'b0;
         last_data = 32'h0;
      end else begin
         ld_neg   = bus.tx_data_valid_o;
         pop_pend = bus.fifo_valid_i && bus.fifo_ready_o;
         if (bus.tx_done_i) done_cyc.push_back(cyc);
         if (bus.tx_data_valid_o) begin
            n_issue++;
            issue_cyc.push_back(cyc);
            chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("tx_data", bus.tx_data_o, e.data);
               chk("fifo_ready", 32'(bus.fifo_ready_o), 32'(e.pop));
               chk("tx_counter", 32'(bus.tx_counter_o), 32'(e.tgt));
               chk("counter_upd", 32'(bus.tx_counter_upd_o), 32'd1);
               chk("issue_pad", 32'(bus.tx_pad_mode_o), 32'(e.pad));
               chk("issue_en_quad", 32'(bus.tx_en_quad_o), 32'(e.quad));
               last_data = e.data;
            end
         end else begin
            chk("idle_strobes", 32'({bus.fifo_ready_o, bus.tx_counter_upd_o}), 32'd0);
            chk("tx_data_hold", bus.tx_data_o, last_data);
         end
         if (bus.done_o) begin
            n_done++;
            chk("done_expected", 32'(dn_q.size() != 0), 32'd1);
            if (dn_q.size() != 0) begin
               d = dn_q.pop_front();
               chk("done_words_sent", 32'(bus.words_sent_o), 32'(d.ws));
               chk("done_underrun", 32'(bus.underrun_o), 32'(d.urun));
               chk("done_busy", 32'(bus.busy_o), 32'd1);
               chk("done_pad", 32'(bus.tx_pad_mode_o), 32'd1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start_i = 1'b0;
      bus.quad_i  = 1'b0;
      bus.dummy_i = 8'd0;
      bus.words_i = 16'd0;

      // Reset state
      repeat (2) @(posedge sclk);
      @(negedge sclk);
      check_reset("rst");
      @(posedge sclk);
      #1 cs = 1'b0;

      // std, no dummy, two words
      @(negedge sclk);
      fifo_q.push_back(32'hA5A5_A5A5);
      fifo_q.push_back(32'h0F0F_0F0F);
      exp_issue(32'hA5A5_A5A5, 1'b1, 1'b0);
      exp_issue(32'h0F0F_0F0F, 1'b1, 1'b0);
      exp_done(16'd2, 1'b0);
      p0 = n_pop;
      start_xfer(1'b0, 8'd0, 16'd2);
      @(negedge sclk);
      chk("t1_busy", 32'(bus.busy_o), 32'd1);
      wait_done(100, "t1_done_seen");
      @(negedge sclk);
      chk("t1_idle_busy", 32'(bus.busy_o), 32'd0);
      chk("t1_idle_pad", 32'(bus.tx_pad_mode_o), 32'd1);
      chk("t1_words_sent", 32'(bus.words_sent_o), 32'd2);
      chk("t1_pops", 32'(n_pop - p0), 32'd2);

      // quad, 4 dummy cycles, one word
      fifo_q.push_back(32'h1234_5678);
      exp_issue(32'h1234_5678, 1'b1, 1'b1);
      exp_done(16'd1, 1'b0);
      start_xfer(1'b1, 8'd4, 16'd1);
      repeat (4) begin
         @(negedge sclk);
         chk("t2_dummy_pad", 32'(bus.tx_pad_mode_o), 32'd1);
         chk("t2_dummy_noissue", 32'(bus.tx_data_valid_o), 32'd0);
         chk("t2_dummy_busy", 32'(bus.busy_o), 32'd1);
      end
      wait_done(100, "t2_done_seen");
      @(negedge sclk);
      chk("t2_idle_pad", 32'(bus.tx_pad_mode_o), 32'd1);
      chk("t2_words_sent", 32'(bus.words_sent_o), 32'd1);

      // underrun on the second word, FIFO refilled for the third
      fifo_q.push_back(32'h1111_2222);
      exp_issue(32'h1111_2222, 1'b1, 1'b0);
      exp_issue(32'hDEAD_BEEF, 1'b0, 1'b0);
      exp_issue(32'h3333_4444, 1'b1, 1'b0);
      exp_done(16'd3, 1'b1);
      b = n_issue;
      start_xfer(1'b0, 8'd0, 16'd3);
      k = 0;
      while (n_issue < b + 2 && k < 50) begin
         @(posedge sclk);
         k++;
      end
      chk("t3_second_issue", 32'(n_issue >= b + 2), 32'd1);
      @(negedge sclk);
      chk("t3_underrun_set", 32'(bus.underrun_o), 32'd1);
      fifo_q.push_back(32'h3333_4444);
      wait_done(100, "t3_done_seen");
      @(negedge sclk);
      chk("t3_underrun_sticky", 32'(bus.underrun_o), 32'd1);
      chk("t3_words_sent", 32'(bus.words_sent_o), 32'd3);

      // unbounded transfer aborted by cs after 5 word boundaries
      p0 = n_pop;
      for (int i = 0; i < 6; i++) begin
         fifo_q.push_back(32'h6000_0000 + 32'(i));
         exp_issue(32'h6000_0000 + 32'(i), 1'b1, 1'b0);
      end
      b = n_txdone;
      start_xfer(1'b0, 8'd0, 16'd0);
      k = 0;
      while (n_txdone < b + 5 && k < 200) begin
         @(posedge sclk);
         k++;
      end
      chk("t4_five_done", 32'(n_txdone >= b + 5), 32'd1);
      @(negedge sclk);
      chk("t4_words_sent", 32'(bus.words_sent_o), 32'd6);
      chk("t4_busy", 32'(bus.busy_o), 32'd1);
      #2 cs = 1'b1;
      #1;
      check_reset("t4_abort");
      chk("t4_all_issued", 32'(exp_q.size()), 32'd0);
      chk("t4_pops", 32'(n_pop - p0), 32'd6);
      @(posedge sclk);
      #1 cs = 1'b0;
      @(negedge sclk);
      chk("t4_after_pad", 32'(bus.tx_pad_mode_o), 32'd1);
      chk("t4_after_busy", 32'(bus.busy_o), 32'd0);

      // start while busy is ignored; chained word has no gap
      fifo_q.push_back(32'hB000_0001);
      fifo_q.push_back(32'hB000_0002);
      exp_issue(32'hB000_0001, 1'b1, 1'b0);
      exp_issue(32'hB000_0002, 1'b1, 1'b0);
      exp_done(16'd2, 1'b0);
      issue_cyc.delete();
      done_cyc.delete();
      start_xfer(1'b0, 8'd0, 16'd2);
      @(negedge sclk);
      @(posedge sclk);
      #1;
      bus.start_i = 1'b1;
      bus.quad_i  = 1'b1;
      bus.dummy_i = 8'd5;
      bus.words_i = 16'd7;
      @(posedge sclk);
      #1;
      bus.start_i = 1'b0;
      bus.quad_i  = 1'b0;
      bus.dummy_i = 8'd0;
      bus.words_i = 16'd0;
      wait_done(100, "t5_done_seen");
      @(negedge sclk);
      chk("t5_idle_busy", 32'(bus.busy_o), 32'd0);
      chk("t5_issue_count", 32'(issue_cyc.size()), 32'd2);
      chk("t5_done_count", 32'(done_cyc.size()), 32'd2);
      if (issue_cyc.size() > 1 && done_cyc.size() > 0)
         chk("t5_no_gap", 32'(issue_cyc[1]), 32'(done_cyc[0]));

      // stray tx_done in IDLE
      force_done = 1'b1;
      @(negedge sclk);
      force_done = 1'b0;
      repeat (2) @(negedge sclk);
      chk("t5_stray_busy", 32'(bus.busy_o), 32'd0);
      chk("t5_stray_words", 32'(bus.words_sent_o), 32'd2);

      repeat (3) @(negedge sclk);
      chk("end_issue_queue", 32'(exp_q.size()), 32'd0);
      chk("end_done_queue", 32'(dn_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
